// File: rtl/prach_pkg.sv
// Shared types and constants for the PRACH radix-3 DIT frame sequencer.
package prach_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DRAIN
  } seq_state_t;

  localparam int BF3_LATENCY = 5;
  localparam int GRP_W_DFLT  = 12;
  localparam int OCNT_W      = GRP_W_DFLT + 2;

endpackage

// File: rtl/prach_ditfft3_seq.sv
// Frame sequencer feeding the radix-3 DIT butterfly: gates samples to frames,
// marks group starts with m_sync, flags stream violations and signals frame completion.
module prach_ditfft3_seq
  import prach_pkg::*;
#(
  parameter int GRP_W = GRP_W_DFLT,
  parameter int DW    = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic [GRP_W-1:0] cfg_groups,
  input  logic [DW-1:0]    s_dr,
  input  logic [DW-1:0]    s_di,
  input  logic             s_dv,
  input  logic             s_sof,
  output logic [DW-1:0]    m_dr,
  output logic [DW-1:0]    m_di,
  output logic             m_dv,
  output logic             m_sync,
  input  logic             bf_dv,
  output logic             busy,
  output logic             frame_done,
  output logic             err_gap,
  output logic             err_sof,
  output seq_state_t       dbg_state
);

  // Stream handshake: a sample is taken whenever s_dv=1 (no backpressure);
  // m_dv marks a sample forwarded to the butterfly, one cycle after s_dv.
  localparam int              CNT_W      = GRP_W + 2;
  localparam logic [2:0]      BLANK_INIT = 3'(BF3_LATENCY);

  seq_state_t       state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic [GRP_W-1:0] groups_q, groups_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic [2:0]       blank_q, blank_d;
  logic             err_gap_q, err_gap_d;
  logic             err_sof_q, err_sof_d;
  logic             done_q, done_d;
  logic [DW-1:0]    m_dr_q, m_dr_d, m_di_q, m_di_d;
  logic             m_dv_q, m_dv_d, m_sync_q, m_sync_d;

  logic             accept, sync, bf_cnt;
  logic [CNT_W-1:0] target;

  assign target = CNT_W'(groups_q) * CNT_W'(3);
  // Outputs of a frame that was cut short still return for one butterfly
  // latency after a (re)start; the blanking window keeps them out of ocnt.
  assign bf_cnt = bf_dv && (blank_q == 3'd0);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    grp_d     = grp_q;
    groups_d  = groups_q;
    ocnt_d    = ocnt_q;
    blank_d   = (blank_q != 3'd0) ? blank_q - 3'd1 : 3'd0;
    err_gap_d = err_gap_q;
    err_sof_d = err_sof_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    sync      = 1'b0;
    if (!cfg_en) begin
      state_d   = IDLE;
      phase_d   = 2'd0;
      grp_d     = '0;
      ocnt_d    = '0;
      blank_d   = 3'd0;
      err_gap_d = 1'b0;
      err_sof_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (s_dv && s_sof) begin
            accept   = 1'b1;
            sync     = 1'b1;
            phase_d  = 2'd1;
            grp_d    = '0;
            ocnt_d   = '0;
            blank_d  = BLANK_INIT;
            groups_d = (cfg_groups == '0) ? GRP_W'(1) : cfg_groups;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (s_dv && s_sof) begin
            err_sof_d = 1'b1;
            accept    = 1'b1;
            sync      = 1'b1;
            phase_d   = 2'd1;
            grp_d     = '0;
            ocnt_d    = '0;
            blank_d   = BLANK_INIT;
          end else if (!s_dv && (phase_q != 2'd0)) begin
            err_gap_d = 1'b1;
            phase_d   = 2'd0;
            grp_d     = '0;
            ocnt_d    = '0;
            state_d   = ARMED;
          end else begin
            if (bf_cnt) ocnt_d = ocnt_q + CNT_W'(1);
            if (s_dv) begin
              accept = 1'b1;
              sync   = (phase_q == 2'd0);
              if (phase_q == 2'd2) begin
                phase_d = 2'd0;
                grp_d   = grp_q + GRP_W'(1);
                if (grp_q == groups_q - GRP_W'(1)) state_d = DRAIN;
              end else begin
                phase_d = phase_q + 2'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (bf_cnt) begin
            if (ocnt_q + CNT_W'(1) == target) begin
              done_d  = 1'b1;
              ocnt_d  = '0;
              grp_d   = '0;
              phase_d = 2'd0;
              state_d = ARMED;
            end else begin
              ocnt_d = ocnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    m_dv_d   = accept;
    m_sync_d = sync;
    m_dr_d   = accept ? s_dr : m_dr_q;
    m_di_d   = accept ? s_di : m_di_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= 2'd0;
      grp_q     <= '0;
      groups_q  <= '0;
      ocnt_q    <= '0;
      blank_q   <= 3'd0;
      err_gap_q <= 1'b0;
      err_sof_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      grp_q     <= grp_d;
      groups_q  <= groups_d;
      ocnt_q    <= ocnt_d;
      blank_q   <= blank_d;
      err_gap_q <= err_gap_d;
      err_sof_q <= err_sof_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dr_q   <= '0;
      m_di_q   <= '0;
      m_dv_q   <= 1'b0;
      m_sync_q <= 1'b0;
    end else begin
      m_dr_q   <= m_dr_d;
      m_di_q   <= m_di_d;
      m_dv_q   <= m_dv_d;
      m_sync_q <= m_sync_d;
    end
  end

  assign m_dr       = m_dr_q;
  assign m_di       = m_di_q;
  assign m_dv       = m_dv_q;
  assign m_sync     = m_sync_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign frame_done = done_q;
  assign err_gap    = err_gap_q;
  assign err_sof    = err_sof_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_prach_ditfft3_seq.sv
// Directed bench for the PRACH radix-3 frame sequencer with a 5-cycle butterfly loopback.
module tb_prach_ditfft3_seq;
  import prach_pkg::*;

  localparam int GRP_W = 12;
  localparam int DW    = 18;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_en = 1'b0;
  logic [GRP_W-1:0] cfg_groups = '0;
  logic [DW-1:0]    s_dr = '0, s_di = '0;
  logic             s_dv = 1'b0, s_sof = 1'b0;
  logic [DW-1:0]    m_dr, m_di;
  logic             m_dv, m_sync, bf_dv, busy, frame_done, err_gap, err_sof;
  seq_state_t       dbg_state;
  logic [4:0]       bf_pipe;

  int checks = 0;
  int errors = 0;

  prach_ditfft3_seq #(.GRP_W(GRP_W), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_groups(cfg_groups),
    .s_dr(s_dr), .s_di(s_di), .s_dv(s_dv), .s_sof(s_sof),
    .m_dr(m_dr), .m_di(m_di), .m_dv(m_dv), .m_sync(m_sync),
    .bf_dv(bf_dv), .busy(busy), .frame_done(frame_done),
    .err_gap(err_gap), .err_sof(err_sof), .dbg_state(dbg_state)
  );

  // clock / reset / butterfly loopback: bf_dv follows m_dv by 5 cycles
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bf_pipe <= '0;
    else        bf_pipe <= {bf_pipe[3:0], m_dv};
  end
  assign bf_dv = bf_pipe[4];

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic sof, input int d);
    s_dv  = dv;
    s_sof = sof;
    s_dr  = DW'(d);
    s_di  = DW'(d + 1000);
    @(posedge clk);
    #1;
  endtask

  // Idles the input for n cycles, then checks pulse count and position
  task automatic wait_done(input string tag, input int n, input int exp_cnt, input int exp_at);
    int cnt = 0;
    int at  = -1;
    for (int k = 1; k <= n; k++) begin
      drive(1'b0, 1'b0, 0);
      if (frame_done) begin
        cnt++;
        if (at < 0) at = k;
      end
    end
    check({tag, "_done_cnt"}, 32'(cnt), 32'(exp_cnt));
    if (exp_cnt > 0) check({tag, "_done_at"}, 32'(at), 32'(exp_at));
  endtask

  initial begin
    int bad;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_m_dv", 32'(m_dv), 0);
    check("rst_m_sync", 32'(m_sync), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: four contiguous groups
    cfg_groups = 12'd4;
    cfg_en     = 1'b1;
    drive(1'b0, 1'b0, 0);
    check("t1_armed", 32'(dbg_state), 32'(ARMED));
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, i == 0, i);
      if (m_dv !== 1'b1 || m_sync !== ((i % 3) == 0) || m_dr !== DW'(i) || busy !== 1'b1) bad++;
    end
    check("t1_stream", 32'(bad), 0);
    check("t1_m_di", 32'(m_di), 32'(1011));
    check("t1_drain", 32'(dbg_state), 32'(DRAIN));
    wait_done("t1", 10, 1, 6);
    check("t1_after_state", 32'(dbg_state), 32'(ARMED));
    check("t1_after_busy", 32'(busy), 0);
    check("t1_err", 32'({err_gap, err_sof}), 0);

    // 2: samples before sof are dropped
    cfg_groups = 12'd2;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 100 + i);
      if (m_dv !== 1'b0) bad++;
    end
    check("t2_dropped", 32'(bad), 0);
    check("t2_hold_m_dr", 32'(m_dr), 32'(11));
    drive(1'b1, 1'b1, 200);
    check("t2_sof_sync", 32'({m_dv, m_sync}), 32'(3));
    check("t2_sof_data", 32'(m_dr), 32'(200));
    for (int i = 1; i < 6; i++) drive(1'b1, 1'b0, 200 + i);
    check("t2_sync_g1", 32'(m_sync), 0);
    wait_done("t2", 10, 1, 6);

    // 3: gap inside a group
    cfg_groups = 12'd3;
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 300 + i);
    drive(1'b0, 1'b0, 0);
    check("t3_err_gap", 32'(err_gap), 1);
    check("t3_state", 32'(dbg_state), 32'(ARMED));
    drive(1'b0, 1'b0, 0);
    bad = 0;
    for (int i = 4; i < 8; i++) begin
      drive(1'b1, 1'b0, 300 + i);
      if (m_dv !== 1'b0) bad++;
    end
    check("t3_no_m_dv", 32'(bad), 0);
    wait_done("t3", 15, 0, 0);
    check("t3_err_sticky", 32'(err_gap), 1);
    cfg_en = 1'b0;
    drive(1'b0, 1'b0, 0);
    check("t3_err_clr", 32'(err_gap), 0);
    check("t3_idle", 32'(dbg_state), 32'(IDLE));

    // 4: legal gap between groups
    cfg_en     = 1'b1;
    cfg_groups = 12'd2;
    drive(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 400 + i);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0);
    check("t4_gap_busy", 32'(busy), 1);
    check("t4_gap_err", 32'(err_gap), 0);
    drive(1'b1, 1'b0, 403);
    check("t4_sync_after_gap", 32'({m_dv, m_sync}), 32'(3));
    drive(1'b1, 1'b0, 404);
    drive(1'b1, 1'b0, 405);
    check("t4_drain", 32'(dbg_state), 32'(DRAIN));
    wait_done("t4", 10, 1, 6);
    check("t4_err", 32'({err_gap, err_sof}), 0);

    // 5: sof restart mid frame
    cfg_groups = 12'd4;
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, 500 + i);
    drive(1'b1, 1'b1, 507);
    check("t5_err_sof", 32'(err_sof), 1);
    check("t5_restart_sync", 32'({m_dv, m_sync}), 32'(3));
    check("t5_state", 32'(dbg_state), 32'(RUN));
    bad = 0;
    for (int i = 1; i < 12; i++) begin
      drive(1'b1, 1'b0, 507 + i);
      if (m_sync !== ((i % 3) == 0)) bad++;
    end
    check("t5_syncs", 32'(bad), 0);
    check("t5_drain", 32'(dbg_state), 32'(DRAIN));
    wait_done("t5", 10, 1, 6);

    // 6: asynchronous reset mid frame
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 600 + i);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", 32'({m_dv, m_sync, busy, frame_done, err_gap, err_sof}), 0);
    check("t6_rst_m_dr", 32'(m_dr), 0);
    check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 0);
    check("t6_armed", 32'(dbg_state), 32'(ARMED));
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 700 + i);
      if (m_dv !== 1'b0) bad++;
    end
    check("t6_wait_sof", 32'(bad), 0);
    drive(1'b1, 1'b1, 710);
    check("t6_sof_sync", 32'({m_dv, m_sync, busy}), 32'(7));

    s_dv = 1'b0;
    s_sof = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
